// File: rtl/mac_seq_ctrl.sv
// Job-framed Q-format dot-product sequencer.
// Two-stage round/saturate multiply feeding a saturating accumulator.
module mac_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 9,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int PW = 2*DATA_W + 1;

  localparam logic [DATA_W-1:0] MAXV =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic              sat_q;
  logic [DATA_W-1:0] s1_r;
  logic              s1_v;
  logic              s1_sat;

  logic              hs;
  logic              last;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [PW-1:0]       pr;
  logic signed [PW-1:0]       ps;
  logic                       p_ovf;
  logic [DATA_W-1:0]          p_r;

  logic [DATA_W:0]   sum;
  logic              a_ovf;
  logic [DATA_W-1:0] acc_nx;

  assign in_ready  = (state == RUN) && (cnt < len_q);
  assign hs        = in_valid & in_ready;
  assign last      = hs && (cnt == len_q - 1'b1);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = acc;
  assign out_sat   = sat_q;

  // Round half up, then check the shifted value fits DATA_W.
  assign prod = $signed(in_a) * $signed(in_b);
  assign pr   = {prod[2*DATA_W-1], prod}
              + {{(PW-FRAC){1'b0}}, 1'b1,
                 {(FRAC-1){1'b0}}};
  assign ps   = pr >>> FRAC;

  always_comb begin
    p_ovf = ~((&ps[PW-1:DATA_W-1]) |
              (~|ps[PW-1:DATA_W-1]));
    p_r   = ps[DATA_W-1:0];
    if (p_ovf) p_r = ps[PW-1] ? MINV : MAXV;
  end

  assign sum = {acc[DATA_W-1], acc}
             + {s1_r[DATA_W-1], s1_r};

  always_comb begin
    a_ovf  = sum[DATA_W] ^ sum[DATA_W-1];
    acc_nx = sum[DATA_W-1:0];
    if (a_ovf) acc_nx = sum[DATA_W] ? MINV : MAXV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      len_q  <= '0;
      cnt    <= '0;
      acc    <= '0;
      sat_q  <= 1'b0;
      s1_r   <= '0;
      s1_v   <= 1'b0;
      s1_sat <= 1'b0;
    end else begin
      s1_v <= hs;
      if (hs) begin
        s1_r   <= p_r;
        s1_sat <= p_ovf;
      end
      if (s1_v) begin
        acc   <= acc_nx;
        sat_q <= sat_q | s1_sat | a_ovf;
      end
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            cnt   <= '0;
            acc   <= '0;
            sat_q <= 1'b0;
            state <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (hs) cnt <= cnt + 1'b1;
          if (last) state <= FLUSH;
        end
        FLUSH: state <= DONE;
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the fixed-point multiply-accumulate datapath. It accepts a job length, consumes exactly that many operand pairs over a valid/ready stream, and computes a Q-format dot product through a 2-stage multiply/accumulate pipeline with rounding and saturation. It returns the result over a valid/ready output. It sits between the operand-fetch logic and the result writeback, replacing free-running, input-change-triggered accumulation with explicit job framing.

## Interface
Parameters:
- DATA_W, 16, operand/result width (two's complement)
- FRAC, 9, fractional bits of operands and result
- LEN_W, 8, width of job length

Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  job request, sampled only in IDLE
- len  in  LEN_W  number of operand pairs, sampled with start
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller accepts a pair this cycle
- in_a, in_b  in  DATA_W  signed operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  signed dot-product result
- out_sat  out  1  saturation occurred anywhere in this job (sticky per job)
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: start=1 latches len, clears accumulator, sat flag and pair counter. If len=0, go to DONE; otherwise go to RUN.
- RUN: in_ready = (count < len). A handshake (in_valid & in_ready) increments count and loads stage 1. When the last pair is accepted, go to FLUSH.
- FLUSH: one cycle, in_ready=0. Stage 2 absorbs the final product, then go to DONE.
- DONE: out_valid=1 and out_data/out_sat held stable until out_valid & out_ready. Then go to IDLE.
- start outside IDLE is ignored. len is ignored except at accepted start.
- Stage 1 (product): p = in_a*in_b as a full 2·DATA_W signed product. r = (p + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half up). r is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The stage holds r plus a valid bit; it carries a bubble when no handshake occurs.
- Stage 2 (accumulate): when the stage-1 valid bit is set, acc = sat(acc + r) using a DATA_W+1-bit sum clamped to the signed DATA_W range.
- out_sat is set if any product or accumulate step clamped during the job.
- out_data = acc.

## Timing
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0, accumulator=0, pipeline valid bits=0.
- rst at any edge, including mid-RUN or DONE, forces the reset values at that edge. A partial job is discarded and the result is never presented.
- Start accepted at edge T: busy=1 and the state is RUN (or DONE if len=0) from T. For len=0, out_valid=1 from T with out_data=0.
- Last handshake at edge E: stage 1 loads at E, the state is FLUSH during cycle E→E+1, the accumulator updates at E+1, and out_valid=1 from E+1.
- Throughput: 1 pair/cycle while in_valid is held high. Minimum job time is len+1 cycles from start to out_valid.
- The result handshake at edge H gives IDLE from H. The next start can be accepted at H+1.
- in_ready never asserts in IDLE, FLUSH or DONE. No more than len pairs are ever consumed.

## Test plan
- len=3, three pairs 0x0200×0x0200 (1.0×1.0), in_valid held high -> out_data=0x0600, out_sat=0, out_valid exactly 2 edges after the 3rd handshake.
- Rounding, len=3: 0x0001×0x0100, 0x0001×0x00FF, 0xFFFF×0x0100 -> per-pair r = 1, 0, 0; out_data=0x0001, out_sat=0.
- Saturation, len=2: 0x7FFF×0x7FFF then 0x0200×0x0200 -> out_data=0x7FFF, out_sat=1. Repeat with 0x8000×0x7FFF then 0xFE00×0x0200 -> out_data=0x8000, out_sat=1.
- Handshake stalls: len=4 with in_valid bubbles between pairs, out_ready held low for 5 cycles, start pulsed during DONE -> correct sum, out_data stable while waiting, in_ready=0, start ignored, busy=1 until the result handshake.
- len=0 -> out_valid one edge after start, out_data=0x0000, out_sat=0, no input consumed.
- rst after 2 of 4 pairs -> all outputs at reset values next cycle. A new len=1 job 0x0400×0x0200 then yields 0x0400 with no residue from the aborted job.
